conv_addr_gen: RTL and testbench

CONV_ADDR_GEN -- requirements
Module: conv_addr_gen

---
 rtl/conv_addr_gen.sv | 164 ++++++++++++++++
 tb/tb_conv_addr_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_addr_gen.sv
// conv_addr_gen
// Address generator for a KxK convolution over a single image. For each
// output position (orow, ocol) it emits the K*K input-window read
// addresses in row-major tap order, then one write address for the result.
// It walks all OUT_ROWS x OUT_COLS positions and pulses done after the
// final write has been accepted.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin one full image pass; only looked at while idle
//   addr_ready : consumer accepts addr_out this cycle
//   addr_valid : addr_out / rw / kr / kc are valid
//   addr_out   : memory address (registered)
//   rw         : 0 = window tap read, 1 = result write (registered)
//   kr, kc     : current tap row / column, 0 during a write (registered)
//   busy       : a pass is in progress
//   done       : one-cycle pulse after the last write is accepted
module conv_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int K          = 3,
  parameter int ROW_STRIDE = 1024,
  parameter int OUT_COLS   = 4,
  parameter int OUT_ROWS   = 2,
  parameter logic [ADDR_W-1:0] IN_BASE  = '0,
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(32'h0001_0000),
  localparam int KW = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic              rw,
  output logic [KW-1:0]     kr,
  output logic [KW-1:0]     kc,
  output logic              busy,
  output logic              done
);

  localparam int RW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int CW_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            state;
  logic [RW_W-1:0]   orow;
  logic [CW_W-1:0]   ocol;

  state_t            n_state;
  logic [KW-1:0]     n_kr;
  logic [KW-1:0]     n_kc;
  logic [RW_W-1:0]   n_orow;
  logic [CW_W-1:0]   n_ocol;
  logic              n_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] n_addr;

  // Next-state and next-index computation. addr_valid is always high in
  // READ and WRITE, so addr_ready alone decides whether a transfer happens.
  // The address for the following cycle is derived from the next indices,
  // which lets every output leave the block straight from a flop.
  always_comb begin
    n_state = state;
    n_kr    = kr;
    n_kc    = kc;
    n_orow  = orow;
    n_ocol  = ocol;
    n_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          n_state = S_READ;
          n_kr    = '0;
          n_kc    = '0;
          n_orow  = '0;
          n_ocol  = '0;
        end
      end
      S_READ: begin
        if (addr_ready) begin
          if (kc == KW'(K - 1)) begin
            n_kc = '0;
            if (kr == KW'(K - 1)) begin
              n_kr    = '0;
              n_state = S_WRITE;
            end else begin
              n_kr = kr + KW'(1);
            end
          end else begin
            n_kc = kc + KW'(1);
          end
        end
      end
      S_WRITE: begin
        if (addr_ready) begin
          n_state = S_READ;
          if (ocol == CW_W'(OUT_COLS - 1)) begin
            n_ocol = '0;
            if (orow == RW_W'(OUT_ROWS - 1)) begin
              n_orow  = '0;
              n_state = S_IDLE;
              n_done  = 1'b1;
            end else begin
              n_orow = orow + RW_W'(1);
            end
          end else begin
            n_ocol = ocol + CW_W'(1);
          end
        end
      end
      default: n_state = S_IDLE;
    endcase

    // All arithmetic at ADDR_W bits so it wraps modulo 2^ADDR_W.
    rd_addr = IN_BASE
            + ADDR_W'(ROW_STRIDE) * (ADDR_W'(n_orow) + ADDR_W'(n_kr))
            + ADDR_W'(n_ocol) + ADDR_W'(n_kc);
    wr_addr = OUT_BASE + ADDR_W'(n_orow) * ADDR_W'(OUT_COLS) + ADDR_W'(n_ocol);

    if (n_state == S_READ) begin
      n_addr = rd_addr;
    end else if (n_state == S_WRITE) begin
      n_addr = wr_addr;
    end else begin
      n_addr = '0;
    end
  end

  // State and registered outputs. Without a transfer the next values equal
  // the current ones, so everything holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      kr         <= '0;
      kc         <= '0;
      orow       <= '0;
      ocol       <= '0;
      addr_valid <= 1'b0;
      addr_out   <= '0;
      rw         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= n_state;
      kr         <= n_kr;
      kc         <= n_kc;
      orow       <= n_orow;
      ocol       <= n_ocol;
      addr_valid <= (n_state != S_IDLE);
      busy       <= (n_state != S_IDLE);
      rw         <= (n_state == S_WRITE);
      addr_out   <= n_addr;
      done       <= n_done;
    end
  end

endmodule

// File: tb/tb_conv_addr_gen.sv
// tb_conv_addr_gen
// Self-checking bench for conv_addr_gen. A default-parameter instance is
// checked against a scoreboard of expected (address, rw) transfers built
// from an independent model of the window walk; a second instance with
// K=1, OUT_COLS=2, OUT_ROWS=1 is checked against a fixed table.
module tb_conv_addr_gen;

  localparam int TK      = 3;
  localparam int TSTRIDE = 1024;
  localparam int TCOLS   = 4;
  localparam int TROWS   = 2;
  localparam logic [31:0] TIN  = 32'h0000_0000;
  localparam logic [31:0] TOUT = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        valid;
  logic [31:0] addr;
  logic        rw;
  logic [1:0]  kr;
  logic [1:0]  kc;
  logic        busy;
  logic        done;

  logic        start1 = 1'b0;
  logic        ready1 = 1'b1;
  logic        valid1;
  logic [31:0] addr1;
  logic        rw1;
  logic [0:0]  kr1;
  logic [0:0]  kc1;
  logic        busy1;
  logic        done1;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  int   xfer_count = 0;
  logic done_exp = 1'b0;

  conv_addr_gen #(
    .ADDR_W(32), .K(TK), .ROW_STRIDE(TSTRIDE), .OUT_COLS(TCOLS),
    .OUT_ROWS(TROWS), .IN_BASE(TIN), .OUT_BASE(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_ready(ready),
    .addr_valid(valid), .addr_out(addr), .rw(rw), .kr(kr), .kc(kc),
    .busy(busy), .done(done)
  );

  conv_addr_gen #(
    .ADDR_W(32), .K(1), .ROW_STRIDE(TSTRIDE), .OUT_COLS(2),
    .OUT_ROWS(1), .IN_BASE(TIN), .OUT_BASE(TOUT)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .addr_ready(ready1),
    .addr_valid(valid1), .addr_out(addr1), .rw(rw1), .kr(kr1), .kc(kc1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected transfers of one full pass, walked independently of the RTL.
  task automatic pushPass();
    exp_t e;
    for (int r = 0; r < TROWS; r++) begin
      for (int c = 0; c < TCOLS; c++) begin
        for (int i = 0; i < TK; i++) begin
          for (int j = 0; j < TK; j++) begin
            e.addr = TIN + 32'((r + i) * TSTRIDE + c + j);
            e.rw   = 1'b0;
            e.last = 1'b0;
            sb.push_back(e);
          end
        end
        e.addr = TOUT + 32'(r * TCOLS + c);
        e.rw   = 1'b1;
        e.last = (r == TROWS - 1) && (c == TCOLS - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Queue the expected pass and pulse start for one cycle.
  task automatic applyStimulus();
    pushPass();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDrained(input int max_cycles, input bit random_ready);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < max_cycles) begin
      if (random_ready) ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ready = 1'b1;
    tick();
    checkOutput("drain_queue", 32'(sb.size()), 0);
    checkOutput("drain_busy", {31'b0, busy}, 0);
  endtask

  // Scoreboard monitor: pops on every accepted transfer and checks that
  // done pulses exactly in the cycle after the final write.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_exp = 1'b0;
    end else begin
      checkOutput("done", {31'b0, done}, {31'b0, done_exp});
      if (done) done_count++;
      done_exp = 1'b0;
      if (valid && ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_xfer_queue", 32'(sb.size()), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("addr", addr, e.addr);
          checkOutput("rw", {31'b0, rw}, {31'b0, e.rw});
          done_exp = e.last;
          xfer_count++;
        end
      end
    end
  end

  initial begin
    logic [31:0] k1_addr [4];
    logic        k1_rw   [4];
    int          n;
    int          idle;
    int          d0;
    int          x0;

    k1_addr[0] = 32'h0;     k1_rw[0] = 1'b0;
    k1_addr[1] = 32'h10000; k1_rw[1] = 1'b1;
    k1_addr[2] = 32'h1;     k1_rw[2] = 1'b0;
    k1_addr[3] = 32'h10001; k1_rw[3] = 1'b1;

    // Asynchronous reset with no clock edge needed.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", {31'b0, valid}, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_rw", {31'b0, rw}, 0);
    checkOutput("rst_kr", {30'b0, kr}, 0);
    checkOutput("rst_kc", {30'b0, kc}, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_done", {31'b0, done}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_after_rst", {31'b0, valid}, 0);

    // Full pass with ready always high: 80 transfers, one done pulse.
    d0 = done_count;
    x0 = xfer_count;
    applyStimulus();
    waitDrained(200, 1'b0);
    checkOutput("pass_xfers", 32'(xfer_count - x0), 80);
    checkOutput("pass_dones", 32'(done_count - d0), 1);

    // Full pass with random backpressure.
    applyStimulus();
    waitDrained(2000, 1'b1);

    // Stall at tap (1,2) for 5 cycles.
    applyStimulus();
    n = 0;
    while (!(valid && kr == 2'd1 && kc == 2'd2) && n < 50) begin
      tick();
      n++;
    end
    checkOutput("stall_reached", 32'(n < 50), 1);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_addr", addr, 32'd1026);
      checkOutput("stall_valid", {31'b0, valid}, 1);
    end
    tick();
    ready = 1'b1;
    waitDrained(200, 1'b0);

    // Reset in the middle of the write for position (0,2).
    applyStimulus();
    n = 0;
    while (!(valid && rw && addr == 32'h10002) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("wr02_reached", 32'(n < 100), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'b0, valid}, 0);
    checkOutput("midrst_addr", addr, 0);
    checkOutput("midrst_rw", {31'b0, rw}, 0);
    checkOutput("midrst_busy", {31'b0, busy}, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("midrst_idle", {31'b0, valid}, 0);
    applyStimulus();
    waitDrained(200, 1'b0);

    // start held high: two back-to-back passes with only the done cycle idle.
    d0 = done_count;
    pushPass();
    pushPass();
    start = 1'b1;
    tick();
    idle = 0;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (sb.size() == 0) break;
      if (!valid) idle++;
    end
    start = 1'b0;
    tick();
    tick();
    checkOutput("b2b_idle_cycles", 32'(idle), 1);
    checkOutput("b2b_queue", 32'(sb.size()), 0);
    checkOutput("b2b_dones", 32'(done_count - d0), 2);
    checkOutput("b2b_busy", {31'b0, busy}, 0);

    // K=1, 2x1 output: alternating single read and write.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("k1_valid", {31'b0, valid1}, 1);
      checkOutput("k1_addr", addr1, k1_addr[i]);
      checkOutput("k1_rw", {31'b0, rw1}, {31'b0, k1_rw[i]});
    end
    @(negedge clk);
    checkOutput("k1_done", {31'b0, done1}, 1);
    checkOutput("k1_idle", {31'b0, valid1}, 0);
    @(negedge clk);
    checkOutput("k1_done_once", {31'b0, done1}, 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
